// File: rtl/dds_pkg.sv
// dds_pkg: shared waveform codes, register map and commit FSM states
package dds_pkg;
    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;
    localparam logic [1:0] ADDR_FWORD  = 2'd0;
    localparam logic [1:0] ADDR_WAVE   = 2'd1;
    localparam logic [1:0] ADDR_PHASE  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;
    typedef enum logic [1:0] {IDLE, ARMED, APPLY} cfg_state_e;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus stable-low counter, one press pulse per hold
module key_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic key_in,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // counter saturates one past the pulse point so a held key never repeats
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_in};
            cnt   <= sync[1] ? '0 : (cnt == CW'(DEB_CYCLES) ? cnt : cnt + 1'b1);
            press <= !sync[1] && cnt == CW'(DEB_CYCLES - 1);
        end
    end
endmodule

// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl: key/CPU configuration of the DDS, committed glitch-free at a channel-A wrap
module dds_cfg_ctrl
    import dds_pkg::*;
#(
    parameter int          DEB_CYCLES   = 1_000_000,
    parameter logic [31:0] FSTEP        = 32'd85899,
    parameter logic [31:0] FMIN         = 32'd85899,
    parameter logic [31:0] FMAX         = 32'd858993459,
    parameter logic [31:0] FWORD_INIT   = 32'd85899,
    parameter logic [15:0] WRAP_TIMEOUT = 16'd65535
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        key0_in,
    input  logic        key1_in,
    input  logic        key2_in,
    input  logic        cfg_wr_en,
    input  logic        cfg_rd_en,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    input  logic        phase_wrap_a,
    output logic [31:0] fword,
    output logic [1:0]  wave_sel,
    output logic [13:0] phase_ofs_b,
    output logic        upd_pulse,
    output logic        busy
);
    logic [2:0]  keys;
    logic [2:0]  press;
    cfg_state_e  state, state_d;
    logic [31:0] pend_fword;
    logic [1:0]  pend_wave;
    logic [13:0] pend_phase;
    logic        lock, dirty;
    logic [15:0] tcnt;
    logic        key_ok, k_wave, k_up, k_dn, wr_pend, force_apply, edit, timeout, apply;
    logic [31:0] fw_clamp, fw_up, fw_dn, rd_mux;

    assign keys = {key2_in, key1_in, key0_in};
    assign busy = state == ARMED;

    for (genvar g = 0; g < 3; g++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .sys_clk(sys_clk),
            .rst    (rst),
            .key_in (keys[g]),
            .press  (press[g])
        );
    end

    // a CPU write on the same cycle swallows every key pulse
    always_comb begin
        key_ok      = !lock && !cfg_wr_en;
        k_wave      = key_ok && press[0];
        k_up        = key_ok && press[1] && !press[2];
        k_dn        = key_ok && press[2] && !press[1];
        wr_pend     = cfg_wr_en && cfg_addr != ADDR_CTRL;
        force_apply = cfg_wr_en && cfg_addr == ADDR_CTRL && cfg_wdata[1];
        edit        = wr_pend || k_wave || k_up || k_dn;
        timeout     = tcnt == WRAP_TIMEOUT - 16'd1;
        apply       = state == APPLY;
        fw_clamp    = cfg_wdata < FMIN ? FMIN : (cfg_wdata > FMAX ? FMAX : cfg_wdata);
        fw_up       = pend_fword > FMAX - FSTEP ? FMAX : pend_fword + FSTEP;
        fw_dn       = pend_fword < FMIN + FSTEP ? FMIN : pend_fword - FSTEP;
        rd_mux      = cfg_addr == ADDR_FWORD ? fword :
                      cfg_addr == ADDR_WAVE  ? {30'b0, wave_sel} :
                      cfg_addr == ADDR_PHASE ? {18'b0, phase_ofs_b} : {30'b0, busy, lock};
        state_d     = state == IDLE  ? (force_apply ? APPLY : (dirty ? ARMED : IDLE)) :
                      state == ARMED ? ((phase_wrap_a || force_apply || timeout) ? APPLY : ARMED) :
                      IDLE;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            fword       <= FWORD_INIT;
            wave_sel    <= WAVE_SINE;
            phase_ofs_b <= '0;
            pend_fword  <= FWORD_INIT;
            pend_wave   <= WAVE_SINE;
            pend_phase  <= '0;
            lock        <= 1'b0;
            dirty       <= 1'b0;
            tcnt        <= '0;
            upd_pulse   <= 1'b0;
            cfg_rdata   <= '0;
        end else begin
            if (cfg_wr_en && cfg_addr == ADDR_FWORD) pend_fword <= fw_clamp;
            if (cfg_wr_en && cfg_addr == ADDR_WAVE)  pend_wave  <= cfg_wdata[1:0];
            if (cfg_wr_en && cfg_addr == ADDR_PHASE) pend_phase <= cfg_wdata[13:0];
            if (cfg_wr_en && cfg_addr == ADDR_CTRL)  lock       <= cfg_wdata[0];
            if (k_wave) pend_wave  <= pend_wave + 2'd1;
            if (k_up)   pend_fword <= fw_up;
            if (k_dn)   pend_fword <= fw_dn;
            dirty     <= edit || (dirty && !apply);
            tcnt      <= busy ? tcnt + 16'd1 : '0;
            upd_pulse <= apply;
            if (apply) begin
                fword       <= pend_fword;
                wave_sel    <= pend_wave;
                phase_ofs_b <= pend_phase;
            end
            if (cfg_rd_en) cfg_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// tb_dds_cfg_ctrl: scoreboard bench for dds_cfg_ctrl against a behavioural register model
module tb_dds_cfg_ctrl;
    localparam int          DEB   = 16;
    localparam int          TMO   = 100;
    localparam logic [31:0] FSTEP = 32'd85899;
    localparam logic [31:0] FMIN  = 32'd85899;
    localparam logic [31:0] FMAX  = 32'd858993459;
    localparam logic [31:0] FINIT = 32'd85899;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  keys = 3'b111;
    logic        cfg_wr_en = 1'b0, cfg_rd_en = 1'b0, phase_wrap_a = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata, fword;
    logic [1:0]  wave_sel;
    logic [13:0] phase_ofs_b;
    logic        upd_pulse, busy;

    dds_cfg_ctrl #(.DEB_CYCLES(DEB), .WRAP_TIMEOUT(16'(TMO))) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .key0_in     (keys[0]),
        .key1_in     (keys[1]),
        .key2_in     (keys[2]),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_rd_en   (cfg_rd_en),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .phase_wrap_a(phase_wrap_a),
        .fword       (fword),
        .wave_sel    (wave_sel),
        .phase_ofs_b (phase_ofs_b),
        .upd_pulse   (upd_pulse),
        .busy        (busy)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] f;
        logic [1:0]  w;
        logic [13:0] p;
    } cfg_t;

    cfg_t        exp_q[$];
    int          checks = 0, errors = 0, upd_cnt = 0;
    bit          upd_prev = 0;
    logic [31:0] m_fword;
    logic [1:0]  m_wave;
    logic [13:0] m_phase;
    logic        m_lock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // every committed configuration must match the oldest expected snapshot
    always @(negedge sys_clk) begin
        if (rst) upd_prev = 0;
        else begin
            if (upd_prev) chk("upd_width", upd_pulse, 0);
            if (upd_pulse) begin
                cfg_t e;
                upd_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: got upd_pulse=1 expected 0 (fword %0d)", fword);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_fword", fword, e.f);
                    chk("upd_wave", 32'(wave_sel), 32'(e.w));
                    chk("upd_phase", 32'(phase_ofs_b), 32'(e.p));
                end
            end
            upd_prev = upd_pulse;
        end
    end

    task automatic m_reset();
        m_fword = FINIT; m_wave = 0; m_phase = 0; m_lock = 0;
    endtask

    task automatic m_key(input int k);
        if (m_lock) return;
        if (k == 0) m_wave = 2'((int'(m_wave) + 1) % 4);
        if (k == 1) m_fword = (m_fword > FMAX - FSTEP) ? FMAX : m_fword + FSTEP;
        if (k == 2) m_fword = (m_fword < FMIN + FSTEP) ? FMIN : m_fword - FSTEP;
    endtask

    task automatic m_write(input int a, input logic [31:0] d);
        if (a == 0) m_fword = d < FMIN ? FMIN : (d > FMAX ? FMAX : d);
        if (a == 1) m_wave = d[1:0];
        if (a == 2) m_phase = d[13:0];
        if (a == 3) m_lock = d[0];
    endtask

    task automatic push_cur();
        exp_q.push_back('{m_fword, m_wave, m_phase});
    endtask

    task automatic cpu_wr(input int a, input logic [31:0] d);
        @(negedge sys_clk);
        cfg_wr_en = 1; cfg_addr = 2'(a); cfg_wdata = d;
        @(negedge sys_clk);
        cfg_wr_en = 0;
        m_write(a, d);
    endtask

    task automatic cpu_rd(input int a, input logic [31:0] exp, input string nm);
        @(negedge sys_clk);
        cfg_rd_en = 1; cfg_addr = 2'(a);
        @(negedge sys_clk);
        cfg_rd_en = 0;
        chk(nm, cfg_rdata, exp);
    endtask

    task automatic press(input int k, input int lowc);
        @(negedge sys_clk);
        keys[k] = 0;
        repeat (lowc) @(negedge sys_clk);
        keys[k] = 1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (busy !== lvl && n < maxc) begin
            @(negedge sys_clk);
            n++;
        end
        chk(nm, busy, lvl);
    endtask

    task automatic commit_wrap();
        int n0, n;
        wait_busy(1, 40, "arm_before_wrap");
        push_cur();
        n0 = upd_cnt;
        @(negedge sys_clk) phase_wrap_a = 1;
        @(negedge sys_clk) phase_wrap_a = 0;
        n = 0;
        while (upd_cnt == n0 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        chk("wrap_upd_count", upd_cnt - n0, 1);
    endtask

    task automatic commit_force();
        wait_busy(1, 40, "arm_before_force");
        push_cur();
        cpu_wr(3, 2);
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        int r, k, n;
        logic [31:0] d;
        logic [1:0]  v;
        m_reset();
        repeat (3) @(negedge sys_clk);
        chk("rst_fword", fword, FINIT);
        chk("rst_wave", 32'(wave_sel), 0);
        chk("rst_phase", 32'(phase_ofs_b), 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd_pulse, 0);
        chk("rst_rdata", cfg_rdata, 0);
        rst = 0;
        repeat (2) @(negedge sys_clk);

        keys[0] = 0;
        repeat (10) @(negedge sys_clk);
        keys[0] = 1;
        repeat (DEB + 6) @(negedge sys_clk);
        chk("glitch_busy", busy, 0);
        press(0, 40);
        m_key(0);
        chk("press_busy", busy, 1);
        commit_wrap();
        chk("wave_after_wrap", 32'(wave_sel), 1);

        for (int i = 0; i < 4; i++) begin
            press(0, DEB + 8);
            m_key(0);
            commit_wrap();
        end
        chk("wave_after_four", 32'(wave_sel), 1);

        cpu_wr(0, FMAX - 10);
        press(1, DEB + 8);
        m_key(1);
        commit_wrap();
        chk("sat_max", fword, 32'd858993459);
        cpu_wr(0, FMIN + 5);
        press(2, DEB + 8);
        m_key(2);
        commit_wrap();
        chk("sat_min", fword, FMIN);
        cpu_rd(0, m_fword, "rd_fword");
        cpu_rd(1, 32'(m_wave), "rd_wave");
        cpu_rd(2, 32'(m_phase), "rd_phase");
        cpu_rd(3, 0, "rd_ctrl");

        v = 2'((int'(m_wave) + 2) % 4);
        @(negedge sys_clk);
        keys[0] = 0;
        repeat (DEB + 1) @(negedge sys_clk);
        cfg_wr_en = 1; cfg_addr = 1; cfg_wdata = 32'(v);
        repeat (3) @(negedge sys_clk);
        cfg_wr_en = 0;
        m_write(1, 32'(v));
        repeat (8) @(negedge sys_clk);
        keys[0] = 1;
        repeat (4) @(negedge sys_clk);
        commit_wrap();
        chk("wr_beats_key", 32'(wave_sel), 32'(v));

        cpu_wr(3, 1);
        cpu_rd(3, 1, "rd_lock");
        press(0, DEB + 8);
        chk("lock_key0_busy", busy, 0);
        press(1, DEB + 8);
        chk("lock_key1_busy", busy, 0);
        cpu_wr(3, 0);
        @(negedge sys_clk);
        keys[1] = 0; keys[2] = 0;
        repeat (DEB + 8) @(negedge sys_clk);
        keys[1] = 1; keys[2] = 1;
        repeat (4) @(negedge sys_clk);
        chk("updn_cancel_busy", busy, 0);

        cpu_wr(2, $urandom);
        push_cur();
        wait_busy(1, 5, "tmo_arm");
        n = 0;
        while (busy && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk("timeout_cycles", n, TMO);
        repeat (3) @(negedge sys_clk);
        chk("timeout_phase", 32'(phase_ofs_b), 32'(m_phase));

        cpu_wr(0, $urandom_range(100000, 5000000));
        wait_busy(1, 5, "force_arm");
        push_cur();
        cpu_wr(3, 2);
        chk("force_busy", busy, 0);
        @(negedge sys_clk);
        chk("force_upd", upd_pulse, 1);
        repeat (3) @(negedge sys_clk);
        push_cur();
        cpu_wr(3, 2);
        @(negedge sys_clk);
        chk("force_idle_upd", upd_pulse, 1);
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 4);
            if (r < 3) begin
                d = (r == 0 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 200000)) : $urandom;
                cpu_wr(r, d);
            end else begin
                k = $urandom_range(0, 2);
                press(k, DEB + 8);
                m_key(k);
            end
            if ($urandom_range(0, 1) == 1) commit_wrap();
            else commit_force();
            cpu_rd(0, m_fword, "rand_rd_fword");
        end

        cpu_wr(0, 12345678);
        wait_busy(1, 5, "rst_arm");
        repeat (5) @(negedge sys_clk);
        #3 rst = 1;
        #1;
        chk("midrst_fword", fword, FINIT);
        chk("midrst_busy", busy, 0);
        @(negedge sys_clk);
        rst = 0;
        m_reset();
        repeat (TMO + 20) @(negedge sys_clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fword", fword, FINIT);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
